// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester-side and physical-RAM-side signals of mem_arbiter.
// The master drives requests and RAM read data; the slave is the arbiter.
interface mem_arbiter_if #(
    parameter int CHANNELS = 2,
    parameter int AW       = 32,
    parameter int DW       = 32
);
    logic [CHANNELS-1:0]    chReq, chWrite, chAck;
    logic [CHANNELS*AW-1:0] chAddress;
    logic [CHANNELS*DW-1:0] chWriteData;
    logic [DW-1:0]          chReadData, phRamRead, phRamWrite;
    logic [AW-1:0]          phRamAddress;
    logic                   phReadReq, phWriteReq, busy;
    logic [2:0]             grantId;
    modport master (
        output chReq, chWrite, chAddress, chWriteData, phRamRead,
        input  chAck, chReadData, phRamAddress, phRamWrite, phReadReq, phWriteReq, busy, grantId
    );
    modport slave (
        input  chReq, chWrite, chAddress, chWriteData, phRamRead,
        output chAck, chReadData, phRamAddress, phRamWrite, phReadReq, phWriteReq, busy, grantId
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one fixed-latency RAM port among CHANNELS requesters.
// One transaction at a time: grant, one-cycle strobe, LATENCY wait, one-cycle ack.
module mem_arbiter #(
    parameter int CHANNELS = 2,
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int LATENCY  = 2
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    localparam logic [CHANNELS-1:0] ONE = CHANNELS'(1);
    state_t              r_state, w_next;
    logic [2:0]          r_rr, r_gid, w_pick, w_hi, w_lo;
    logic                w_found_hi, w_any, w_wr;
    logic [CHANNELS-1:0] w_sel, r_ack;
    logic [3:0]          r_cnt;
    logic                r_write, r_rd_req, r_wr_req;
    logic [AW-1:0]       r_addr;
    logic [DW-1:0]       r_wdata, r_rdata;

    // descending scan leaves the lowest requester at/after r_rr, else the lowest overall
    always_comb begin
        w_hi       = '0;
        w_lo       = '0;
        w_found_hi = 1'b0;
        w_any      = |bus.chReq;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (bus.chReq[i]) begin
                w_lo = 3'(i);
                if (3'(i) >= r_rr) begin
                    w_hi       = 3'(i);
                    w_found_hi = 1'b1;
                end
            end
        end
        w_pick = w_found_hi ? w_hi : w_lo;
        w_sel  = ONE << w_pick;
        w_wr   = |(bus.chWrite & w_sel);
    end

    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_any ? ISSUE : IDLE;
            ISSUE:   w_next = WAIT;
            WAIT:    w_next = (r_cnt == 4'(LATENCY)) ? DONE : WAIT;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rr     <= '0;
            r_gid    <= '0;
            r_cnt    <= '0;
            r_write  <= 1'b0;
            r_rd_req <= 1'b0;
            r_wr_req <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_ack    <= '0;
        end else begin
            r_rd_req <= 1'b0;
            r_wr_req <= 1'b0;
            r_ack    <= '0;
            r_cnt    <= (r_state == WAIT) ? r_cnt + 4'd1 : 4'd1;
            if (r_state == IDLE && w_any) begin
                r_gid    <= w_pick;
                r_rr     <= (w_pick == 3'(CHANNELS - 1)) ? 3'd0 : w_pick + 3'd1;
                r_write  <= w_wr;
                r_addr   <= bus.chAddress[w_pick*AW +: AW];
                r_wdata  <= bus.chWriteData[w_pick*DW +: DW];
                r_rd_req <= ~w_wr;
                r_wr_req <= w_wr;
            end
            if (r_state == WAIT && r_cnt == 4'(LATENCY)) begin
                if (!r_write) r_rdata <= bus.phRamRead;
                r_ack <= ONE << r_gid;
            end
        end
    end

    assign bus.chAck        = r_ack;
    assign bus.chReadData   = r_rdata;
    assign bus.phRamAddress = r_addr;
    assign bus.phRamWrite   = r_wdata;
    assign bus.phReadReq    = r_rd_req;
    assign bus.phWriteReq   = r_wr_req;
    assign bus.busy         = (r_state != IDLE);
    assign bus.grantId      = r_gid;
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter CHANNELS, default 2, number of requester channels (legal 2..8).
REQ-002 Parameter AW, default 32, address width.
REQ-003 Parameter DW, default 32, data width.
REQ-004 Parameter LATENCY, default 2, fixed physical RAM read latency in cycles (legal 1..15).
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 reset  in  1  synchronous, active-low reset; asserted when 0, sampled on rising clk.
REQ-007 chReq  in  CHANNELS  per-channel request level; bit i = channel i.
REQ-008 chWrite  in  CHANNELS  per-channel op: 1 write, 0 read.
REQ-009 chAddress  in  CHANNELS*AW  channel i address at [i*AW +: AW].
REQ-010 chWriteData  in  CHANNELS*DW  channel i write data at [i*DW +: DW].
REQ-011 chAck  out  CHANNELS  one-cycle completion pulse to the granted channel.
REQ-012 chReadData  out  DW  read data; valid in the chAck cycle of a read.
REQ-013 phRamRead  in  DW  physical RAM read data.
REQ-014 phRamAddress  out  AW  physical RAM address.
REQ-015 phRamWrite  out  DW  physical RAM write data.
REQ-016 phReadReq  out  1  physical read strobe.
REQ-017 phWriteReq  out  1  physical write strobe.
REQ-018 busy  out  1  high whenever state is not IDLE.
REQ-019 grantId  out  3  index of the granted channel; meaningful while busy.

Function
REQ-020 The block SHALL implement states IDLE, ISSUE, WAIT, DONE; all outputs registered.
REQ-021 IDLE: if any chReq bit is set, the block SHALL grant the first requesting channel at or after rrPtr (wrapping modulo CHANNELS), latch its index, chWrite, chAddress and chWriteData, and go to ISSUE; otherwise stay in IDLE.
REQ-022 After a grant of channel g, rrPtr SHALL become (g+1) mod CHANNELS.
REQ-023 ISSUE (cycle T): exactly one of phReadReq/phWriteReq SHALL be high for that single cycle, with phRamAddress/phRamWrite driving the latched values; the next state SHALL be WAIT.
REQ-024 WAIT SHALL last until cycle T+LATENCY inclusive; on the edge ending cycle T+LATENCY a read SHALL capture phRamRead into chReadData; writes capture nothing.
REQ-025 DONE (cycle T+LATENCY+1): chAck[g] SHALL be high for exactly that cycle, then the state SHALL return to IDLE.
REQ-026 Latency from the IDLE grant cycle to chAck SHALL be LATENCY+2 cycles; sustained throughput is one transaction per LATENCY+3 cycles.
REQ-027 A requester SHALL hold chReq and its fields stable until chAck and drop chReq on the edge ending the chAck cycle; earliest re-request is visible 2 cycles after chAck.
REQ-028 A granted transaction SHALL complete and acknowledge even if chReq[g] drops mid-transaction; latched fields SHALL NOT change until the next grant.
REQ-029 phRamAddress, phRamWrite and grantId SHALL hold their last values in IDLE; chReadData SHALL hold its last read value until the next read capture.
REQ-030 Simultaneous requests SHALL be served one per transaction in round-robin order; no channel waits more than CHANNELS-1 transactions.
REQ-031 Only one of phReadReq/phWriteReq SHALL ever be high; neither is high outside ISSUE.

Reset
REQ-032 While reset is 0 at a rising edge, the block SHALL enter IDLE with rrPtr=0 and all outputs 0, including mid-transaction; no chAck SHALL be issued for an aborted transaction.
REQ-033 The first grant after reset release SHALL follow REQ-021 with rrPtr=0.

Verification
REQ-034 Single read, LATENCY=2: ch0 reads 0x100, RAM returns 0xDEADBEEF at T+2 -> phReadReq pulse at T, chAck[0] at T+3, chReadData=0xDEADBEEF.
REQ-035 Single write: ch1 writes 0x55AA to 0x20 -> one-cycle phWriteReq with phRamAddress=0x20, phRamWrite=0x55AA; chAck[1] at T+3; chReadData unchanged.
REQ-036 Contention, CHANNELS=4: all channels request at once from reset -> grants in order 0,1,2,3, then 0; each chAck exactly once per request.
REQ-037 Latency sweep: LATENCY=1 and 15 -> chAck exactly LATENCY+2 cycles after grant; read data captured from cycle T+LATENCY only.
REQ-038 Reset mid-WAIT: reset=0 during WAIT -> next cycle busy=0, no chAck, rrPtr=0; a subsequent request completes normally.
